// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus bundle between the CPU pins and the memory responder.
// The master drives a bus cycle request; the slave answers with rdy/ack/rdata/hit.
interface cpu_bus_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  r_w_n;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdy;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  hit;

  modport master (
    output req, addr, r_w_n, wdata,
    input  rdy, ack, rdata, hit
  );

  modport slave (
    input  req, addr, r_w_n, wdata,
    output rdy, ack, rdata, hit
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU bus: mirrored work RAM, programmable wait states,
// and open-bus data for unmapped reads. One bus cycle in flight at a time.
module cpu_bus_responder #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    RAM_ADDR_BITS = 11,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE      = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] RAM_LIMIT     = 16'h1FFF,
  parameter int                    WAIT_STATES   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  cpu_bus_responder_if.slave  bus
);

  localparam int                    RAM_DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [ADDR_WIDTH-1:0] RAM_SPAN  = RAM_LIMIT - RAM_BASE;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [3:0]               r_cnt;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_rd;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [DATA_WIDTH-1:0]    r_obus;
  logic [DATA_WIDTH-1:0]    r_ram [RAM_DEPTH];

  logic                     w_accept;
  logic [ADDR_WIDTH-1:0]    w_off;
  logic                     w_in_ram;
  logic [RAM_ADDR_BITS-1:0] w_idx;
  logic [DATA_WIDTH-1:0]    w_rd_val;

  assign w_accept = (r_state == S_IDLE) && bus.req;

  // Offset compare keeps the window check a single unsigned compare for any base.
  assign w_off    = r_addr - RAM_BASE;
  assign w_in_ram = (w_off <= RAM_SPAN);
  assign w_idx    = r_addr[RAM_ADDR_BITS-1:0];
  assign w_rd_val = w_in_ram ? r_ram[w_idx] : r_obus;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rdy   = (r_state == S_IDLE);
    bus.ack   = (r_state == S_RESP);
    bus.hit   = bus.ack && w_in_ram;
    bus.rdata = (bus.ack && r_rd) ? w_rd_val : r_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_obus  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_addr  <= bus.addr;
        r_rd    <= bus.r_w_n;
        r_wdata <= bus.wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RESP) begin
        if (r_rd) r_rdata <= w_rd_val;
        r_obus <= r_rd ? w_rd_val : r_wdata;
      end
    end
  end

  // RAM has no reset; a reset landing on the RESP edge discards the write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_state == S_RESP) && !r_rd && w_in_ram)
      r_ram[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: three instances with 1, 3 and 0 wait states.
module tb_cpu_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        t_req [3];
  logic [15:0] t_addr;
  logic        t_rw;
  logic [7:0]  t_wd;

  cpu_bus_responder_if b0 ();
  cpu_bus_responder_if b1 ();
  cpu_bus_responder_if b2 ();

  assign b0.req = t_req[0]; assign b0.addr = t_addr; assign b0.r_w_n = t_rw; assign b0.wdata = t_wd;
  assign b1.req = t_req[1]; assign b1.addr = t_addr; assign b1.r_w_n = t_rw; assign b1.wdata = t_wd;
  assign b2.req = t_req[2]; assign b2.addr = t_addr; assign b2.r_w_n = t_rw; assign b2.wdata = t_wd;

  cpu_bus_responder #(.WAIT_STATES(1)) u_ws1 (.i_clk(clk), .i_reset(rst), .bus(b0));
  cpu_bus_responder #(.WAIT_STATES(3)) u_ws3 (.i_clk(clk), .i_reset(rst), .bus(b1));
  cpu_bus_responder #(.WAIT_STATES(0)) u_ws0 (.i_clk(clk), .i_reset(rst), .bus(b2));

  logic       rdy_v [3];
  logic       ack_v [3];
  logic       hit_v [3];
  logic [7:0] rd_v  [3];
  assign rdy_v[0] = b0.rdy; assign ack_v[0] = b0.ack; assign hit_v[0] = b0.hit; assign rd_v[0] = b0.rdata;
  assign rdy_v[1] = b1.rdy; assign ack_v[1] = b1.ack; assign hit_v[1] = b1.hit; assign rd_v[1] = b1.rdata;
  assign rdy_v[2] = b2.rdy; assign ack_v[2] = b2.ack; assign hit_v[2] = b2.hit; assign rd_v[2] = b2.rdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus cycle on instance d; lat = cycles from the accepting edge to the ack cycle.
  task automatic op(input int d, input logic rd, input logic [15:0] a, input logic [7:0] wd,
                    output logic [7:0] rdat, output logic h, output int lat, output int lowc);
    @(negedge clk);
    t_req[d] = 1'b1; t_addr = a; t_rw = rd; t_wd = wd;
    @(posedge clk);
    #1 t_req[d] = 1'b0;
    lat = 0; lowc = 0; rdat = '0; h = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!rdy_v[d]) lowc++;
      if (ack_v[d]) begin
        lat = k; rdat = rd_v[d]; h = hit_v[d];
        break;
      end
    end
    @(posedge clk);
    #1 chk("rdy_back", rdy_v[d], 1'b1);
  endtask

  logic       mon_en = 1'b0;
  logic [7:0] mon_q [$];
  always @(negedge clk) if (mon_en && b1.ack) mon_q.push_back(b1.rdata);

  logic [7:0] rd;
  logic       h;
  int         lat, lowc;

  initial begin
    for (int i = 0; i < 3; i++) t_req[i] = 1'b0;
    t_addr = '0; t_rw = 1'b1; t_wd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", b0.rdy, 1'b1);
    chk("rst_ack", b0.ack, 1'b0);
    chk("rst_rdata", b0.rdata, 8'h00);
    chk("rst_hit", b0.hit, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a write's wait state.
    op(0, 1'b0, 16'h0010, 8'h11, rd, h, lat, lowc);
    op(0, 1'b1, 16'h0010, 8'h00, rd, h, lat, lowc);
    chk("pre_rd", rd, 8'h11);
    @(negedge clk);
    t_req[0] = 1'b1; t_addr = 16'h0010; t_rw = 1'b0; t_wd = 8'h3C;
    @(posedge clk);
    #1 t_req[0] = 1'b0;
    @(negedge clk);
    chk("mid_wait_rdy", b0.rdy, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_rdy", b0.rdy, 1'b1);
    chk("abort_ack", b0.ack, 1'b0);
    chk("abort_rdata", b0.rdata, 8'h00);
    rst = 1'b0;
    op(0, 1'b1, 16'h3000, 8'h00, rd, h, lat, lowc);
    chk("obus_rst", rd, 8'h00);
    op(0, 1'b1, 16'h0010, 8'h00, rd, h, lat, lowc);
    chk("abort_keep", rd, 8'h11);

    // Mirroring with one wait state.
    op(0, 1'b0, 16'h0005, 8'hA5, rd, h, lat, lowc);
    chk("wr_lat", lat, 2);
    chk("wr_hit", h, 1'b1);
    chk("wr_keep_rdata", rd, 8'h11);
    op(0, 1'b1, 16'h0805, 8'h00, rd, h, lat, lowc);
    chk("mirror_0805", rd, 8'hA5);
    chk("mirror_hit", h, 1'b1);
    op(0, 1'b1, 16'h1805, 8'h00, rd, h, lat, lowc);
    chk("mirror_1805", rd, 8'hA5);

    // Open bus.
    op(0, 1'b0, 16'h4020, 8'h5A, rd, h, lat, lowc);
    chk("unm_wr_hit", h, 1'b0);
    chk("unm_wr_lat", lat, 2);
    chk("unm_wr_rdata", rd, 8'hA5);
    op(0, 1'b1, 16'h4020, 8'h00, rd, h, lat, lowc);
    chk("obus_wr", rd, 8'h5A);
    chk("obus_hit", h, 1'b0);
    op(0, 1'b1, 16'h0005, 8'h00, rd, h, lat, lowc);
    chk("ram_0005", rd, 8'hA5);
    op(0, 1'b1, 16'h6000, 8'h00, rd, h, lat, lowc);
    chk("obus_rd", rd, 8'hA5);

    // Window boundary.
    op(0, 1'b0, 16'h1FFF, 8'hFF, rd, h, lat, lowc);
    chk("lim_wr_hit", h, 1'b1);
    op(0, 1'b1, 16'h07FF, 8'h00, rd, h, lat, lowc);
    chk("lim_rd", rd, 8'hFF);
    chk("lim_hit", h, 1'b1);
    op(0, 1'b1, 16'h2000, 8'h00, rd, h, lat, lowc);
    chk("past_lim_rd", rd, 8'hFF);
    chk("past_lim_hit", h, 1'b0);

    // Latency with three and zero wait states.
    op(1, 1'b0, 16'h0001, 8'h11, rd, h, lat, lowc);
    chk("ws3_lat", lat, 4);
    chk("ws3_rdy_low", lowc, 4);
    op(1, 1'b0, 16'h0002, 8'h22, rd, h, lat, lowc);
    op(2, 1'b0, 16'h0003, 8'h77, rd, h, lat, lowc);
    chk("ws0_lat", lat, 1);
    chk("ws0_rdy_low", lowc, 1);
    op(2, 1'b1, 16'h0003, 8'h00, rd, h, lat, lowc);
    chk("ws0_rd", rd, 8'h77);
    chk("ws0_hit", h, 1'b1);

    // req held high while busy: accepts every 5 edges, address at accept edge wins.
    mon_en = 1'b1;
    @(negedge clk);
    t_req[1] = 1'b1; t_rw = 1'b1; t_addr = 16'h0001;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1 t_addr = (i % 2 == 0) ? 16'h0002 : 16'h0001;
    end
    t_req[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold_acks", mon_q.size(), 3);
    if (mon_q.size() == 3) begin
      chk("hold_rd0", mon_q[0], 8'h11);
      chk("hold_rd1", mon_q[1], 8'h22);
      chk("hold_rd2", mon_q[2], 8'h11);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
